// File: rtl/Types.sv
// rtl/Types.sv - shared ray types and default build widths (TAG_SIZE, WIDTH)
`ifndef TAG_SIZE
`define TAG_SIZE 32
`endif
`ifndef WIDTH
`define WIDTH 16
`endif

package Types;
  typedef struct packed {
    logic [`WIDTH-1:0] x;
    logic [`WIDTH-1:0] y;
    logic [`WIDTH-1:0] z;
  } RayDirection;
endpackage

// File: rtl/norm_request_scheduler_pkg.sv
// rtl/norm_request_scheduler_pkg.sv - scheduler state and requester index types
package norm_request_scheduler_pkg;
  // ReqIndex is sized from this default; instances must not exceed it
  localparam int NORM_SCHED_NUM_REQ = 4;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DRAIN = 2'd1,
    DONE  = 2'd2
  } NormSchedState;

  typedef logic [$clog2(NORM_SCHED_NUM_REQ)-1:0] ReqIndex;
endpackage

// File: rtl/norm_request_scheduler_tag_pool.sv
// rtl/norm_request_scheduler_tag_pool.sv - one-hot tag pool with owner table and in-flight counter
module norm_tag_pool
  import norm_request_scheduler_pkg::*;
#(
  parameter int TAG_SIZE     = 32,
  parameter int MAX_INFLIGHT = 32
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              alloc_en,
  input  ReqIndex                           alloc_owner,
  output logic [TAG_SIZE-1:0]               free_tag,
  output logic                              any_free,
  input  logic                              retire_en,
  input  logic [TAG_SIZE-1:0]               retire_tag,
  output logic                              retire_ok,
  output ReqIndex                           retire_owner,
  output logic [$clog2(MAX_INFLIGHT+1)-1:0] inflight
);
  localparam int CNT_W = $clog2(MAX_INFLIGHT+1);

  logic [TAG_SIZE-1:0] used_q, used_d;
  ReqIndex             owner_q [TAG_SIZE];
  ReqIndex             owner_d [TAG_SIZE];
  logic [CNT_W-1:0]    inflight_q, inflight_d;
  logic [TAG_SIZE-1:0] free_mask;
  logic                tag_onehot;

  // Lowest free tag, retired-tag validity and owner lookup (all from registered state)
  always_comb begin
    free_mask    = ~used_q;
    free_tag     = free_mask & (~free_mask + TAG_SIZE'(1));
    any_free     = |free_mask;
    tag_onehot   = (retire_tag != '0) && ((retire_tag & (retire_tag - TAG_SIZE'(1))) == '0);
    retire_ok    = retire_en && tag_onehot && ((retire_tag & used_q) != '0);
    retire_owner = '0;
    for (int i = 0; i < TAG_SIZE; i++) begin
      if (retire_tag[i]) retire_owner = retire_owner | owner_q[i];
    end
  end

  // Next mask/owners/count; the freed bit never overlaps free_tag, so no bypass
  always_comb begin
    used_d     = used_q;
    owner_d    = owner_q;
    inflight_d = inflight_q;
    if (retire_ok) used_d = used_d & ~retire_tag;
    if (alloc_en) begin
      used_d = used_d | free_tag;
      for (int i = 0; i < TAG_SIZE; i++) begin
        if (free_tag[i]) owner_d[i] = alloc_owner;
      end
    end
    if (alloc_en && !retire_ok) inflight_d = inflight_q + CNT_W'(1);
    else if (!alloc_en && retire_ok) inflight_d = inflight_q - CNT_W'(1);
  end

  // Pool state registers
  always_ff @(posedge clk) begin
    if (reset) begin
      used_q     <= '0;
      inflight_q <= '0;
      for (int i = 0; i < TAG_SIZE; i++) owner_q[i] <= '0;
    end else begin
      used_q     <= used_d;
      owner_q    <= owner_d;
      inflight_q <= inflight_d;
    end
  end

  assign inflight = inflight_q;
endmodule

// File: rtl/norm_request_scheduler.sv
// rtl/norm_request_scheduler.sv - round-robin request scheduler with tag pool and flush FSM; optional stats via NORM_SCHED_STATS_EN
module norm_request_scheduler
  import norm_request_scheduler_pkg::*;
  import Types::*;
#(
  parameter int NUM_REQ      = NORM_SCHED_NUM_REQ,
  parameter int TAG_SIZE     = `TAG_SIZE,
  parameter int MAX_INFLIGHT = 32,
  parameter int WIDTH        = `WIDTH
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic [NUM_REQ-1:0]                req_valid,
  input  RayDirection                       req_dir [NUM_REQ],
  output logic [NUM_REQ-1:0]                req_ready,
  output logic                              pipe_start,
  output RayDirection                       pipe_dir,
  output logic [TAG_SIZE-1:0]               pipe_tag,
  input  logic                              pipe_done,
  input  logic [TAG_SIZE-1:0]               pipe_done_tag,
  input  RayDirection                       pipe_normal,
  output logic [NUM_REQ-1:0]                rsp_valid,
  output RayDirection                       rsp_normal,
  input  logic                              flush,
  output logic                              flush_done,
  output logic [$clog2(MAX_INFLIGHT+1)-1:0] inflight,
  output logic                              tag_err
`ifdef NORM_SCHED_STATS_EN
  ,
  output logic [31:0]                       stat_issued,
  output logic [31:0]                       stat_retired,
  output logic [$clog2(MAX_INFLIGHT+1)-1:0] stat_peak_inflight
`endif
);
  localparam int CNT_W = $clog2(MAX_INFLIGHT+1);

  if (WIDTH != $bits(RayDirection) / 3) begin : g_width_check
    $error("WIDTH does not match RayDirection component width");
  end
  if (NUM_REQ > (1 << $bits(ReqIndex)) || MAX_INFLIGHT > TAG_SIZE) begin : g_size_check
    $error("NUM_REQ exceeds ReqIndex range or MAX_INFLIGHT exceeds TAG_SIZE");
  end

  NormSchedState       state_q, state_d;
  ReqIndex             ptr_q, ptr_d, grant_idx;
  logic                grant_found, can_grant, transfer;
  logic                pipe_start_q, pipe_start_d;
  RayDirection         pipe_dir_q, pipe_dir_d, rsp_normal_q, rsp_normal_d;
  logic [TAG_SIZE-1:0] pipe_tag_q, pipe_tag_d, free_tag;
  logic [NUM_REQ-1:0]  rsp_valid_q, rsp_valid_d;
  logic                tag_err_q, tag_err_d;
  logic                any_free, retire_ok;
  ReqIndex             retire_owner;
  logic [CNT_W-1:0]    inflight_w;

  norm_tag_pool #(
    .TAG_SIZE    (TAG_SIZE),
    .MAX_INFLIGHT(MAX_INFLIGHT)
  ) u_tag_pool (
    .clk         (clk),
    .reset       (reset),
    .alloc_en    (transfer),
    .alloc_owner (grant_idx),
    .free_tag    (free_tag),
    .any_free    (any_free),
    .retire_en   (pipe_done),
    .retire_tag  (pipe_done_tag),
    .retire_ok   (retire_ok),
    .retire_owner(retire_owner),
    .inflight    (inflight_w)
  );

  // Round-robin pick: first valid requester at or after the pointer
  always_comb begin
    int j;
    j           = 0;
    grant_found = 1'b0;
    grant_idx   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      j = (int'(ptr_q) + k) % NUM_REQ;
      if (!grant_found && req_valid[j]) begin
        grant_found = 1'b1;
        grant_idx   = ReqIndex'(j);
      end
    end
    can_grant = (state_q == RUN) && !flush && any_free && (inflight_w < CNT_W'(MAX_INFLIGHT));
    transfer  = can_grant && grant_found;
    req_ready = '0;
    if (transfer) req_ready[grant_idx] = 1'b1;
    ptr_d = ptr_q;
    if (transfer) ptr_d = (int'(grant_idx) == NUM_REQ - 1) ? '0 : grant_idx + ReqIndex'(1);
  end

  // Flush FSM: stop granting, wait for the pipeline to empty, pulse done for one cycle
  always_comb begin
    state_d    = state_q;
    flush_done = 1'b0;
    unique case (state_q)
      RUN:     if (flush) state_d = DRAIN;
      DRAIN:   if (inflight_w == '0 && !pipe_start_q) state_d = DONE;
      DONE: begin
        flush_done = 1'b1;
        state_d    = RUN;
      end
      default: state_d = RUN;
    endcase
  end

  // Issue/response output registers and the sticky protocol error
  always_comb begin
    pipe_start_d = transfer;
    pipe_dir_d   = transfer ? req_dir[grant_idx] : pipe_dir_q;
    pipe_tag_d   = transfer ? free_tag : pipe_tag_q;
    rsp_valid_d  = '0;
    if (retire_ok) rsp_valid_d[retire_owner] = 1'b1;
    rsp_normal_d = retire_ok ? pipe_normal : rsp_normal_q;
    tag_err_d    = tag_err_q | (pipe_done && !retire_ok);
  end

  // Scheduler state registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= RUN;
      ptr_q        <= '0;
      pipe_start_q <= 1'b0;
      pipe_dir_q   <= '0;
      pipe_tag_q   <= '0;
      rsp_valid_q  <= '0;
      rsp_normal_q <= '0;
      tag_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      pipe_start_q <= pipe_start_d;
      pipe_dir_q   <= pipe_dir_d;
      pipe_tag_q   <= pipe_tag_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_normal_q <= rsp_normal_d;
      tag_err_q    <= tag_err_d;
    end
  end

  assign pipe_start = pipe_start_q;
  assign pipe_dir   = pipe_dir_q;
  assign pipe_tag   = pipe_tag_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_normal = rsp_normal_q;
  assign tag_err    = tag_err_q;
  assign inflight   = inflight_w;

`ifdef NORM_SCHED_STATS_EN
  logic [31:0]      stat_issued_q, stat_issued_d, stat_retired_q, stat_retired_d;
  logic [CNT_W-1:0] stat_peak_q, stat_peak_d;

  // Free-running wrap-around counters and occupancy high-water mark
  always_comb begin
    stat_issued_d  = stat_issued_q + (transfer ? 32'd1 : 32'd0);
    stat_retired_d = stat_retired_q + (retire_ok ? 32'd1 : 32'd0);
    stat_peak_d    = (inflight_w > stat_peak_q) ? inflight_w : stat_peak_q;
  end

  // Statistics registers
  always_ff @(posedge clk) begin
    if (reset) begin
      stat_issued_q  <= '0;
      stat_retired_q <= '0;
      stat_peak_q    <= '0;
    end else begin
      stat_issued_q  <= stat_issued_d;
      stat_retired_q <= stat_retired_d;
      stat_peak_q    <= stat_peak_d;
    end
  end

  assign stat_issued        = stat_issued_q;
  assign stat_retired       = stat_retired_q;
  assign stat_peak_inflight = stat_peak_q;
`endif
endmodule

// File: doc/norm_request_scheduler.md
# norm_request_scheduler

Front-end scheduler for the normalization pipeline. Arbitrates ray-direction requests from `NUM_REQ` producers round-robin and allocates one-hot tags from a free pool. It caps the in-flight count to protect the downstream buffers and routes each retired normalized result back to the requester that issued it. It also provides a flush/drain sequence so software can quiesce the pipeline.

## Interface
Parameters:
- `NUM_REQ`, 4, number of requesting producers (≥2)
- `TAG_SIZE`, `` `TAG_SIZE ``, tag pool size; tags are one-hot over `TAG_SIZE` bits
- `MAX_INFLIGHT`, 32, in-flight cap; must be ≤ `TAG_SIZE` and ≤ downstream FIFO depth
- `WIDTH`, `` `WIDTH ``, component width of `RayDirection`

Ports (one clock; reset is synchronous and active-high):
- `clk`  in  1  clock
- `reset`  in  1  synchronous, active-high
- `req_valid`  in  NUM_REQ  per-requester request
- `req_dir`  in  RayDirection[NUM_REQ]  per-requester direction
- `req_ready`  out  NUM_REQ  grant; a transfer occurs when `req_valid[i]` and `req_ready[i]` are both high
- `pipe_start`  out  1  issue strobe to the pipeline
- `pipe_dir`  out  RayDirection  issued direction
- `pipe_tag`  out  TAG_SIZE  issued one-hot tag
- `pipe_done`  in  1  pipeline retire strobe
- `pipe_done_tag`  in  TAG_SIZE  retired tag
- `pipe_normal`  in  RayDirection  retired normalized vector
- `rsp_valid`  out  NUM_REQ  one-hot response strobe
- `rsp_normal`  out  RayDirection  response data
- `flush`  in  1  flush request pulse
- `flush_done`  out  1  one-cycle pulse when drained
- `inflight`  out  $clog2(MAX_INFLIGHT+1)  current in-flight count
- `tag_err`  out  1  sticky protocol error

## Operation
- **Grant condition:** state is RUN, `flush` is low, at least one tag is free, and `inflight < MAX_INFLIGHT`.
  - When the condition holds, grant exactly one requester: the first `req_valid` at or after the round-robin pointer.
  - `req_ready` is combinational from the current registered state and `req_valid`.
  - After a transfer, the pointer moves to the granted index + 1, wrapping modulo `NUM_REQ`.
- **Tag allocation:** the allocated tag is the lowest clear bit of the used mask. On transfer:
  - set the bit in the used mask;
  - record the granted index in the owner table at that tag's index;
  - increment `inflight`.
- **Retire:** a retire is valid when `pipe_done` is high and `pipe_done_tag` is exactly one-hot with its bit set in the used mask. On a valid retire:
  - clear the bit;
  - decrement `inflight`;
  - assert `rsp_valid[owner]` and present `rsp_normal` = `pipe_normal`.
- **Invalid retire:** zero, multi-hot, or unused tag. Ignore it and set `tag_err`. `tag_err` is cleared only by reset.
- **Simultaneous allocate and retire:** both take effect; `inflight` is unchanged. A tag freed this cycle is not allocatable until the next cycle (no bypass).
- **Responses are not backpressured.** Requesters must always accept `rsp_valid`.
- **FSM states:**
  - RUN → DRAIN when `flush` is high. No grant is issued in the cycle `flush` is sampled.
  - DRAIN → DONE when `inflight == 0` and `pipe_start` is low.
  - DONE → RUN unconditionally. `flush_done` = 1 in DONE only.
  - `flush` in DRAIN or DONE is ignored. Retires continue to be processed in all states.
- **Reset mid-operation:**
  - clears the used mask, owner table, pointer, `inflight` and `tag_err`;
  - sets the state to RUN;
  - sets all outputs to 0.
  - Results retiring after reset for pre-reset tags are flagged as `tag_err`. Upstream must reset the pipeline together with this block.

## Timing
- **Reset values:** `req_ready`, `pipe_start`, `pipe_dir`, `pipe_tag`, `rsp_valid`, `rsp_normal`, `flush_done`, `inflight`, `tag_err` are all 0.
- **Issue latency:** 1 cycle. `pipe_start`, `pipe_dir` and `pipe_tag` are registered and valid the cycle after the handshake. `pipe_start` is high for exactly one cycle per transfer.
- **Retire latency:** 1 cycle. `rsp_valid` and `rsp_normal` are registered the cycle after `pipe_done`.
- **Occupancy update:** `inflight` updates at the same edge as the handshake and the retire.
- **Throughput:** one issue and one retire per cycle.
- **Full condition:** `req_ready` stays 0 until a retire lands. The first grant after a retire at cycle N appears at cycle N+1.

## Configuration
- **`NORM_SCHED_STATS_EN` defined:** adds three outputs, all reset to 0 and wrapping on overflow:
  - `stat_issued` (32 bit): count of transfers;
  - `stat_retired` (32 bit): count of valid retires;
  - `stat_peak_inflight`: high-water mark of `inflight`.
- **Undefined:** these ports and their registers do not exist. All other behaviour is identical.

## Structure
- **Shared package entries:**
  - `NormSchedState` enum (RUN, DRAIN, DONE);
  - `ReqIndex` typedef (`$clog2(NUM_REQ)` bits).
- `RayDirection` comes from `Types.sv`.
- **One sub-module, `norm_tag_pool`:** holds the used mask, the lowest-free one-hot select, the owner table, the one-hot validity check and the `inflight` counter.
- **Top level:** contains the arbiter, the FSM and the output registers.

## Test plan
- **Single issue and retire:** reset; `req_valid[2]=1`, `dir=(1,0,0)` → `req_ready[2]` high the same cycle, then `pipe_start=1` and `pipe_tag=...0001` at the next cycle. Then `pipe_done` with tag `0001`, `normal=(1,0,0)` → `rsp_valid=0100` one cycle later, `inflight` back to 0.
- **Round-robin fairness:** all 4 requesters held valid for 8 cycles → grant order 0,1,2,3,0,1,2,3; tags 0..7 allocated in order.
- **In-flight cap:** `MAX_INFLIGHT=4`, 4 issues with no retire → `req_ready=0`. Retire tag 1 at cycle N → grant at N+1 with `pipe_tag` bit 1 reused.
- **Simultaneous allocate and retire:** at `inflight=3`, a handshake and a retire of tag 0 in the same cycle → `inflight` stays 3; the new tag is not bit 0.
- **Flush:** 3 in flight, pulse `flush` while `req_valid=1` → no grants until three retires complete. `flush_done` pulses one cycle after the last retire, then grants resume.
- **Errors:** `pipe_done` with tags `0000`, `0011` and an unused one-hot tag → `tag_err=1`, no `rsp_valid`, `inflight` unchanged.
